// File: rtl/wptr_full_pkg.sv
// wptr_full_pkg: shared async-FIFO helpers (Gray conversion, pointer width, DEPTH check)
package wptr_full_pkg;
   localparam int FW = 32;
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
   function automatic bit is_pow2(input int depth);
      return depth >= 4 && (depth & (depth - 1)) == 0;
   endfunction
   function automatic logic [FW-1:0] bin2gray(input logic [FW-1:0] b);
      return b ^ (b >> 1);
   endfunction
   function automatic logic [FW-1:0] gray2bin(input logic [FW-1:0] g);
      logic [FW-1:0] b;
      b = g;
      for (int i = FW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction
endpackage

// File: rtl/wptr_full.sv
// wptr_full: write pointer and full/almost-full/level/overflow status for the async FIFO.
// Ports: w_clk, rst (sync, active-high), w_en, wsync_ptr2 (synced Gray read ptr) in;
// mem_we, waddr, wptr (Gray), w_full, w_almost_full, w_level, w_overflow out.
module wptr_full
   import wptr_full_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 2
) (
   input  logic                      w_clk,
   input  logic                      rst,
   input  logic                      w_en,
   input  logic [$clog2(DEPTH):0]    wsync_ptr2,
   output logic                      mem_we,
   output logic [$clog2(DEPTH)-1:0]  waddr,
   output logic [$clog2(DEPTH):0]    wptr,
   output logic                      w_full,
   output logic                      w_almost_full,
   output logic [$clog2(DEPTH):0]    w_level,
   output logic                      w_overflow
);
   localparam int N  = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   localparam logic [PW-1:0] AF = PW'(AF_THRESH);
   if (!is_pow2(DEPTH) || AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_param
      $error("wptr_full: DEPTH must be a power of two >= 4 and AF_THRESH in 1..DEPTH");
   end
   logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, level_q, level_d, rbin_s;
   logic          full_q, full_d, af_q, af_d, ovf_q, ovf_d, w_inc;
   always_comb begin
      w_inc   = w_en & ~full_q;
      wbin_d  = wbin_q + PW'(w_inc);
      wgray_d = PW'(bin2gray(FW'(wbin_d)));
      rbin_s  = PW'(gray2bin(FW'(wsync_ptr2)));
      // Level uses the post-write pointer so a filling write raises full at the same edge
      level_d = wbin_d - rbin_s;
      full_d  = wgray_d == {~wsync_ptr2[N:N-1], wsync_ptr2[N-2:0]};
      af_d    = level_d >= AF;
      ovf_d   = ovf_q | (w_en & full_q);
   end
   always_ff @(posedge w_clk) begin
      if (rst) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         level_q <= '0;
         full_q  <= 1'b0;
         af_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         level_q <= level_d;
         full_q  <= full_d;
         af_q    <= af_d;
         ovf_q   <= ovf_d;
      end
   end
   assign mem_we        = w_inc;
   assign waddr         = wbin_q[N-1:0];
   assign wptr          = wgray_q;
   assign w_full        = full_q;
   assign w_almost_full = af_q;
   assign w_level       = level_q;
   assign w_overflow    = ovf_q;
endmodule

// File: tb/tb_wptr_full.sv
// tb_wptr_full: randomized self-checking bench for wptr_full (DEPTH=8) against a count-based model
module tb_wptr_full;
   logic       w_clk = 1'b0;
   logic       rst = 1'b0, w_en = 1'b0;
   logic [3:0] wsync_ptr2 = '0, wptr, w_level;
   logic [2:0] waddr;
   logic       mem_we, w_full, w_almost_full, w_overflow;
   logic [13:0] obs;
   int  vectors = 0, miscompares = 0;
   int  wcnt = 0, rc = 0;
   bit  m_ovf = 0, we_exp, we_obs;

   wptr_full #(.DEPTH(8)) dut (
      .w_clk(w_clk), .rst(rst), .w_en(w_en), .wsync_ptr2(wsync_ptr2), .mem_we(mem_we),
      .waddr(waddr), .wptr(wptr), .w_full(w_full), .w_almost_full(w_almost_full),
      .w_level(w_level), .w_overflow(w_overflow)
   );

   always #5 w_clk = ~w_clk;
   assign obs = {w_full, w_almost_full, w_overflow, w_level, wptr, waddr};

   function automatic logic [3:0] gray4(input int v);
      logic [3:0] b;
      b = 4'(v % 16);
      return b ^ (b >> 1);
   endfunction

   // Model: occupancy is writes accepted minus reads visible through the synced pointer
   function automatic logic [13:0] exp_vec();
      int lvl;
      lvl = wcnt - rc;
      return {lvl == 8, lvl >= 6, m_ovf, 4'(lvl), gray4(wcnt), 3'(wcnt % 8)};
   endfunction

   task automatic tick(input bit en, input int rd);
      w_en = en;
      wsync_ptr2 = gray4(rd);
      we_exp = en && (wcnt - rc) != 8;
      #1 we_obs = mem_we;
      @(posedge w_clk);
      if (en && (wcnt - rc) == 8) m_ovf = 1;
      else if (en) wcnt++;
      rc = rd;
      @(negedge w_clk);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      w_en = 1'b1;
      wsync_ptr2 = '0;
      repeat (n) @(posedge w_clk);
      wcnt = 0;
      rc = 0;
      m_ovf = 0;
      @(negedge w_clk);
      rst = 1'b0;
      w_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(2);
      vectors++;
      if (obs !== 14'd0) begin
         miscompares++;
         $display("FAIL reset_state: got %b expected %b", obs, 14'd0);
      end
      tick(0, 0);
      vectors++;
      if (obs !== exp_vec()) begin
         miscompares++;
         $display("FAIL reset_idle: got %b expected %b", obs, exp_vec());
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         tick(1, 0);
         vectors++;
         if (we_obs !== we_exp) begin
            miscompares++;
            $display("FAIL fill_we[%0d]: got %b expected %b", i, we_obs, we_exp);
         end
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL fill[%0d]: got %b expected %b", i, obs, exp_vec());
         end
      end
      vectors++;
      if ({w_full, w_level, wptr} !== {1'b1, 4'd8, 4'b1100}) begin
         miscompares++;
         $display("FAIL fill_full: got full=%b level=%0d wptr=%b expected 1/8/1100", w_full, w_level, wptr);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 3; i++) begin
         tick(1, 0);
         vectors++;
         if (we_obs !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_we[%0d]: got %b expected 0", i, we_obs);
         end
         vectors++;
         if (obs !== exp_vec() || waddr !== 3'd0 || w_overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf[%0d]: got %b expected %b", i, obs, exp_vec());
         end
      end
   endtask

   task automatic test_drain();
      tick(0, 3);
      vectors++;
      if ({w_full, w_level, w_almost_full} !== {1'b0, 4'd5, 1'b0} || obs !== exp_vec()) begin
         miscompares++;
         $display("FAIL drain: got %b expected %b", obs, exp_vec());
      end
   endtask

   task automatic test_wrap();
      logic [3:0] prev;
      int acc, pre, rd;
      bit en;
      acc = 0;
      tick(0, wcnt);
      for (int it = 0; it < 400 && acc < 20; it++) begin
         en = 1'($urandom % 2);
         rd = int'($urandom_range(wcnt, rc));
         if (wcnt + int'(en) - rd > 4) rd = wcnt + int'(en) - 4;
         pre = wcnt;
         prev = wptr;
         tick(en, rd);
         acc += wcnt - pre;
         vectors++;
         if ($countones(prev ^ wptr) != wcnt - pre) begin
            miscompares++;
            $display("FAIL wrap_hamming: %b -> %b expected distance %0d", prev, wptr, wcnt - pre);
         end
         vectors++;
         if (obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL wrap: got %b expected %b", obs, exp_vec());
         end
      end
      vectors++;
      if (acc < 20) begin
         miscompares++;
         $display("FAIL wrap_budget: got %0d writes expected 20", acc);
      end
      for (int it = 0; it < 20 && (wcnt - rc) != 8; it++) tick(1, rc);
      vectors++;
      if (w_full !== 1'b1 || (wptr ^ wsync_ptr2) !== 4'b1100 || obs !== exp_vec()) begin
         miscompares++;
         $display("FAIL wrap_full: got %b wptr^rptr=%b expected %b / 1100", obs, wptr ^ wsync_ptr2, exp_vec());
      end
   endtask

   task automatic test_simul();
      do_reset(1);
      for (int i = 0; i < 8; i++) tick(1, 0);
      tick(1, 1);
      vectors++;
      if (we_obs !== 1'b0) begin
         miscompares++;
         $display("FAIL simul_we: got %b expected 0", we_obs);
      end
      vectors++;
      if ({w_full, w_overflow, w_level} !== {1'b0, 1'b1, 4'd7} || obs !== exp_vec()) begin
         miscompares++;
         $display("FAIL simul: got %b expected %b", obs, exp_vec());
      end
   endtask

   task automatic test_random();
      bit en;
      int rd;
      for (int i = 0; i < 300; i++) begin
         en = 1'($urandom % 3 != 0);
         rd = ($urandom % 2) ? int'($urandom_range(wcnt, rc)) : rc;
         tick(en, rd);
         vectors++;
         if (we_obs !== we_exp || obs !== exp_vec()) begin
            miscompares++;
            $display("FAIL random[%0d]: got we=%b %b expected we=%b %b", i, we_obs, obs, we_exp, exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid();
      tick(1, rc);
      do_reset(1);
      vectors++;
      if (obs !== 14'd0) begin
         miscompares++;
         $display("FAIL reset_mid: got %b expected %b", obs, 14'd0);
      end
   endtask

   initial begin
      @(negedge w_clk);
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_wrap();
      test_simul();
      test_random();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/wptr_full.md
# wptr_full

Write-domain pointer and full-flag generator for the team's asynchronous FIFO, clocked by `w_clk`. It sits directly downstream of the read-to-write pointer synchronizer and consumes its Gray-coded output `wsync_ptr2`. It owns the binary and Gray write pointers, drives the memory write address and enable, and produces registered full, almost-full, fill-level and overflow status. Its Gray write pointer feeds the write-to-read synchronizer.

## Interface
- `DEPTH`, default 8: FIFO entries; power of two, ≥4.
- `AF_THRESH`, default `DEPTH-2`: almost-full threshold in entries; legal range 1..`DEPTH`.
- `w_clk` input 1: write-domain clock. One clock only.
- `rst` input 1: reset, synchronous, active-high.
- `w_en` input 1: write request from the producer.
- `wsync_ptr2` input `$clog2(DEPTH)+1`: Gray read pointer, already synchronized into `w_clk`.
- `mem_we` output 1: memory write enable; combinational `w_en & ~w_full`.
- `waddr` output `$clog2(DEPTH)`: memory write address; low bits of the registered binary pointer.
- `wptr` output `$clog2(DEPTH)+1`: registered Gray write pointer, sent to the write-to-read synchronizer.
- `w_full` output 1: registered full flag.
- `w_almost_full` output 1: registered; asserted when level ≥ `AF_THRESH`.
- `w_level` output `$clog2(DEPTH)+1`: registered, conservative occupancy, 0..`DEPTH`.
- `w_overflow` output 1: sticky; set when a write is attempted while full.

## Operation
- `N = $clog2(DEPTH)`. Pointers are N+1 bits; the MSB is the wrap bit.
- Accept: `w_inc = w_en & ~w_full`. `wbin_next = wbin + w_inc`, modulo 2^(N+1). `wgray_next = bin2gray(wbin_next)`.
- Full, registered: `w_full <= (wgray_next == {~wsync_ptr2[N:N-1], wsync_ptr2[N-2:0]})`.
- Level: `rbin_s = gray2bin(wsync_ptr2)`, combinational. `w_level <= wbin_next - rbin_s`, modulo 2^(N+1); never exceeds `DEPTH`.
- `w_almost_full <= (wbin_next - rbin_s) >= AF_THRESH`.
- `w_overflow` is set by `w_en & w_full`, and cleared only by `rst`.
- A write while full is dropped: no pointer change and `mem_we=0`.
- Read-side progress is seen only through `wsync_ptr2`. Status is pessimistic: full and level may lag real reads by the synchronizer delay plus one cycle. It never under-reports occupancy.
- Reset: `wbin`, `wptr`, `waddr`, `w_level` = 0; `w_full`, `w_almost_full`, `w_overflow` = 0. Reset wins over a same-cycle `w_en`. Reset mid-operation discards all state. The read side must be reset in the same system reset window.

## Timing
- Write accepted at edge k: `waddr`, `wptr`, `w_level` update at edge k; `w_full` asserts at edge k when that write fills the FIFO, so there is no extra-write window.
- `wsync_ptr2` change at edge k: `w_full`, `w_almost_full`, `w_level` reflect it at edge k+1.
- Simultaneous write and `wsync_ptr2` advance: both are applied in the same `wbin_next - rbin_s` evaluation.
- Wrap-around: the binary pointer rolls from 2^(N+1)-1 to 0. The Gray pointer changes exactly one bit per accepted write, including at wrap.
- `mem_we` is combinational; the memory samples `waddr` and data at the same `w_clk` edge.

## Structure
- Shared FIFO package: `bin2gray` and `gray2bin` functions, pointer-width derivation from `DEPTH`, and the `DEPTH` power-of-two check. The read-side empty generator uses the same package.
- No sub-module. Single always block for pointer and flag registers plus combinational next-state logic.

## Test plan
- Reset: assert `rst` for 2 cycles with `w_en=1` → all outputs 0, no pointer movement.
- Fill, `DEPTH=8`, `wsync_ptr2=4'b0000`: 8 consecutive writes → after the 8th, `w_full=1`, `w_level=8`, `wptr=4'b1100`. `w_almost_full` rises after the 6th write.
- Write while full: `w_en=1` for 3 cycles → `waddr` stays 0, `mem_we=0`, `w_overflow=1` and stays 1 until `rst`.
- Drain from full: set `wsync_ptr2=4'b0010` (binary 3) → next edge `w_full=0`, `w_level=5`, `w_almost_full=0`.
- Wrap: 20 writes interleaved with reads that keep level ≤4 → each `wptr` step has a Hamming distance of 1. Full is correctly detected when the pointers differ only in the two MSBs after wrap.
- Simultaneous events: at level 8, `w_en=1` in the same cycle `wsync_ptr2` advances by one → the write is dropped (full that cycle), overflow is set, and full clears next edge.
